// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared branch-op encodings for the branch address unit
package br_pkg;

    typedef enum logic [1:0] {
        BR_JMP  = 2'b00,
        BR_CALL = 2'b01,
        BR_RET  = 2'b10,
        BR_RSV  = 2'b11
    } br_op_t;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - circular return-address stack with saturating count and sticky flags
module ras_lifo #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top_data,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    // ptr is the next slot to write; the top entry sits one below it
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;

    assign ptr_inc  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign ptr_dec  = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
    assign top_data = mem[ptr_dec];
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);

    // When full, the slot at ptr holds the oldest entry, so a push overwrites it
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                ptr <= ptr_dec;
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/br_ras.sv
// rtl/br_ras.sv - branch target calculator with integrated return-address stack
module br_ras
    import br_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          pc_out,
    input  logic [ADDR_W-1:0]          imm,
    input  logic                       br_sel,
    input  br_op_t                     br_op,
    input  logic                       br_en,
    output logic [ADDR_W-1:0]          br_addr,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic [$clog2(DEPTH+1)-1:0] ras_cnt,
    output logic                       ras_ovf,
    output logic                       ras_unf
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top_data;
    logic              push;
    logic              pop;

    assign base     = br_sel ? '0 : pc_out;
    assign ret_addr = pc_out + ADDR_W'(1);
    assign push     = br_en && (br_op == BR_CALL);
    assign pop      = br_en && (br_op == BR_RET);

    always_comb begin
        br_addr = base + imm;
        if (br_op == BR_RET) begin
            br_addr = ras_empty ? '0 : top_data;
        end
    end

    ras_lifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top_data  (top_data),
        .cnt       (ras_cnt),
        .full      (ras_full),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule

// File: tb/tb_br_ras.sv
// tb/tb_br_ras.sv - directed self-checking bench for br_ras
module tb_br_ras;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] imm;
    logic        br_sel;
    br_op_t      br_op;
    logic        br_en;
    logic [15:0] br_addr;
    logic        ras_empty;
    logic        ras_full;
    logic [3:0]  ras_cnt;
    logic        ras_ovf;
    logic        ras_unf;

    int n_checks = 0;
    int n_pass   = 0;

    br_ras #(.ADDR_W(16), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_out    (pc_out),
        .imm       (imm),
        .br_sel    (br_sel),
        .br_op     (br_op),
        .br_en     (br_en),
        .br_addr   (br_addr),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_cnt   (ras_cnt),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input br_op_t op, input logic en, input logic sel,
                         input logic [15:0] pc, input logic [15:0] im);
        br_op  = op;
        br_en  = en;
        br_sel = sel;
        pc_out = pc;
        imm    = im;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(BR_JMP, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_cnt",   32'(ras_cnt),   32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full",  32'(ras_full),  32'd0);
        check("rst_ovf",   32'(ras_ovf),   32'd0);
        check("rst_unf",   32'(ras_unf),   32'd0);

        drive(BR_RET, 1'b1, 1'b0, 16'h1234, 16'h5678);
        check("ret_empty_addr", 32'(br_addr), 32'h0000);
        tick();
        drive(BR_JMP, 1'b0, 1'b0, 16'h0, 16'h0);
        check("unf_set",   32'(ras_unf),   32'd1);
        check("unf_cnt",   32'(ras_cnt),   32'd0);
        check("unf_empty", 32'(ras_empty), 32'd1);

        drive(BR_JMP, 1'b1, 1'b0, 16'h0100, 16'h0010);
        check("jmp_rel", 32'(br_addr), 32'h0110);
        drive(BR_JMP, 1'b1, 1'b1, 16'h0100, 16'h0010);
        check("jmp_abs", 32'(br_addr), 32'h0010);
        drive(BR_JMP, 1'b1, 1'b0, 16'hFFF8, 16'h0010);
        check("jmp_wrap", 32'(br_addr), 32'h0008);
        drive(BR_RSV, 1'b1, 1'b0, 16'h0100, 16'h0010);
        check("rsv_addr", 32'(br_addr), 32'h0110);
        tick();
        check("rsv_nostack", 32'(ras_cnt), 32'd0);

        drive(BR_CALL, 1'b1, 1'b1, 16'h0020, 16'h0100);
        check("call_addr", 32'(br_addr), 32'h0100);
        tick();
        check("call_cnt", 32'(ras_cnt), 32'd1);
        drive(BR_RET, 1'b1, 1'b0, 16'h0100, 16'h0000);
        check("ret_addr", 32'(br_addr), 32'h0021);
        tick();
        check("ret_cnt", 32'(ras_cnt), 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(BR_CALL, 1'b1, 1'b0, 16'(16'h0010 + i), 16'h0004);
            tick();
            if (i == 7) begin
                check("full_after8", 32'(ras_full), 32'd1);
                check("noovf_after8", 32'(ras_ovf), 32'd0);
            end
        end
        check("ovf_after9", 32'(ras_ovf), 32'd1);
        check("cnt_sat", 32'(ras_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            drive(BR_RET, 1'b1, 1'b1, 16'h7777, 16'h3333);
            check($sformatf("pop%0d", i), 32'(br_addr), 32'(16'h0019 - i));
            tick();
        end
        check("pop_empty", 32'(ras_empty), 32'd1);
        check("pop_nounf", 32'(ras_unf), 32'd0);
        drive(BR_RET, 1'b0, 1'b0, 16'h0, 16'h0);
        check("lost_oldest", 32'(br_addr), 32'h0000);

        drive(BR_CALL, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        tick();
        check("call_noen", 32'(ras_cnt), 32'd0);
        drive(BR_CALL, 1'b1, 1'b0, 16'hFFFF, 16'h0002);
        tick();
        check("call_wrap_cnt", 32'(ras_cnt), 32'd1);
        drive(BR_RET, 1'b1, 1'b0, 16'h0040, 16'h0000);
        check("call_wrap_val", 32'(br_addr), 32'h0000);
        tick();
        tick();
        check("unf_again", 32'(ras_unf), 32'd1);

        for (int i = 0; i < 3; i++) begin
            drive(BR_CALL, 1'b1, 1'b0, 16'(16'h0030 + i), 16'h0000);
            tick();
        end
        check("three_calls", 32'(ras_cnt), 32'd3);
        rst = 1'b1;
        drive(BR_RET, 1'b1, 1'b0, 16'h0, 16'h0);
        tick();
        rst = 1'b0;
        drive(BR_JMP, 1'b0, 1'b0, 16'h0, 16'h0);
        check("rstret_cnt",   32'(ras_cnt),   32'd0);
        check("rstret_unf",   32'(ras_unf),   32'd0);
        check("rstret_ovf",   32'(ras_ovf),   32'd0);
        check("rstret_empty", 32'(ras_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/br_ras.md
# br_ras

Parametrised branch address unit with an integrated return-address stack (RAS) for the SISC processor. It computes the branch target for jump, call and return operations in either relative (PC + imm) or absolute (0 + imm) mode. On a call it pushes the return address; on a return it pops it. It sits between the instruction decoder/control unit and the program counter. Like the existing branch calculator, it never decides whether a branch is taken; it only supplies the target address and keeps stack state.

## Interface
Parameters:
- ADDR_W, 16: width of PC, immediate and all addresses.
- DEPTH, 8: number of RAS entries. Must be ≥ 2.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_out  input  ADDR_W  current PC; base for relative targets and for return addresses.
- imm  input  ADDR_W  instruction immediate.
- br_sel  input  1  1 = absolute (base 0), 0 = relative (base pc_out). Ignored for RET.
- br_op  input  2  00 JMP, 01 CALL, 10 RET, 11 reserved (behaves as JMP, no stack effect).
- br_en  input  1  qualifies br_op for this cycle. Stack changes only when br_en = 1.
- br_addr  output  ADDR_W  computed target address. Combinational.
- ras_empty  output  1  count == 0.
- ras_full  output  1  count == DEPTH.
- ras_cnt  output  $clog2(DEPTH+1)  number of valid entries.
- ras_ovf  output  1  sticky: a push occurred while the stack was full.
- ras_unf  output  1  sticky: a pop occurred while the stack was empty.

## Operation
- Target computation, modulo 2^ADDR_W, carries discarded:
  - JMP/CALL/reserved: br_addr = (br_sel ? 0 : pc_out) + imm.
  - RET: br_addr = top-of-stack entry. If the stack is empty, br_addr = 0.
- br_addr is driven by every input in its sensitivity, including br_op and stack state. No latches.
- br_addr is valid whether or not br_en is asserted.
- Return address pushed on CALL = pc_out + 1, modulo 2^ADDR_W (pc_out = all-ones pushes 0).
- CALL with br_en:
  - Push the return address; ras_cnt increments.
  - When full: the oldest entry is overwritten (circular buffer), ras_cnt stays at DEPTH, and ras_ovf is set.
- RET with br_en:
  - Pop; ras_cnt decrements.
  - When empty: ras_cnt stays 0, no pointer movement, and ras_unf is set.
- JMP, reserved, or br_en = 0: no stack change.
- Storage: circular buffer of DEPTH entries with a top pointer that wraps modulo DEPTH, plus a saturating count.
- Reset:
  - ras_cnt = 0, top pointer = 0, ras_ovf = ras_unf = 0.
  - Entry contents are not cleared and are don't-care.
  - ras_empty = 1, ras_full = 0. br_addr then follows the combinational rules, so RET after reset gives 0.
- Reset takes priority over any br_en operation in the same cycle.
- The sticky flags clear only on reset.

## Timing
- br_addr has zero-cycle latency: combinational from inputs and the current stack top.
- Stack, count and flags update on the rising clk edge after br_en is sampled. A popped or pushed value is reflected in br_addr and ras_cnt from the next cycle.
- Back-to-back operations are legal every cycle:
  - CALL in cycle n, then RET in cycle n+1 returns the address pushed in cycle n.
  - Consecutive RETs pop successive entries.
- Only one operation per cycle by construction.

## Structure
- Shared package br_pkg:
  - br_op encodings BR_JMP = 2'b00, BR_CALL = 2'b01, BR_RET = 2'b10, BR_RSV = 2'b11.
  - Typedef for the op field.
- Sub-module ras_lifo:
  - Parametrised on ADDR_W and DEPTH.
  - Ports: push, pop, push_data, top_data, cnt, full, empty, ovf, unf.
  - Contains the circular storage, pointer, count and sticky flags.
- br_ras instantiates ras_lifo and holds the target adder/mux and the return-address incrementer.

## Test plan
- Reset, then RET with br_en = 1 → br_addr = 0x0000; after the edge ras_unf = 1, ras_cnt = 0, ras_empty = 1.
- pc_out = 0x0100, imm = 0x0010: br_sel = 0 → br_addr = 0x0110; br_sel = 1 → 0x0010. pc_out = 0xFFF8, imm = 0x0010, br_sel = 0 → 0x0008 (wrap).
- CALL at pc_out = 0x0020, imm = 0x0100, br_sel = 1 → br_addr = 0x0100. Next cycle RET → br_addr = 0x0021, then ras_cnt returns to 0.
- DEPTH = 8: CALLs at pc_out = 0x10..0x18 (9 pushes) → ras_full after the 8th push, ras_ovf = 1 after the 9th. Eight RETs then yield 0x19, 0x18 … 0x12 and ras_empty = 1; 0x11 is lost.
- CALL with pc_out = 0xFFFF → pushed value 0x0000. Same cycle with br_en = 0 → no push, ras_cnt unchanged.
- Three CALLs, then rst = 1 together with a RET → ras_cnt = 0 and flags clear; the RET has no effect.
